// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - watches data-memory stores and latches a PASS/FAIL/TIMEOUT verdict
module store_monitor #(
  parameter logic [31:0] RESULT_ADR     = 32'd252,
  parameter logic [31:0] EXPECT_DATA    = 32'd9,
  parameter int          STRICT         = 1,
  parameter int          IGNORE_EN      = 0,
  parameter logic [31:0] IGNORE_ADR     = 32'd96,
  parameter int          TIMEOUT_CYCLES = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        Done,
  output logic        Pass,
  output logic        Fail,
  output logic        Timeout,
  output logic [31:0] Score,
  output logic [15:0] StoreCount,
  output logic [15:0] CycleCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT_CYCLES - 1);
  localparam logic        STRICT_ON  = (STRICT != 0);
  localparam logic        IGNORE_ON  = (IGNORE_EN != 0);

  state_t      state_q, state_d;
  logic [31:0] score_q, score_d;
  logic [15:0] store_cnt_q, store_cnt_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic        hit_result;
  logic        hit_ignore;
  logic        hit_other;
  logic        store_ends;

  always_comb begin
    hit_result = MemWrite && (DataAdr == RESULT_ADR);
    hit_ignore = MemWrite && IGNORE_ON && (DataAdr == IGNORE_ADR) && !hit_result;
    hit_other  = MemWrite && !hit_result && !hit_ignore;
    store_ends = hit_result || (hit_other && STRICT_ON);
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    store_cnt_d = store_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    unique case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (MemWrite && (store_cnt_q != 16'hFFFF)) store_cnt_d = store_cnt_q + 16'd1;
        if (cycle_cnt_q != 16'hFFFF) cycle_cnt_d = cycle_cnt_q + 16'd1;
        if (store_ends) begin
          score_d = WriteData;
          state_d = (hit_result && (WriteData == EXPECT_DATA)) ? S_PASS : S_FAIL;
        end else if (cycle_cnt_q == LAST_CYCLE) begin
          // the timeout edge is not counted, so CycleCount ends at TIMEOUT_CYCLES-1
          cycle_cnt_d = cycle_cnt_q;
          state_d     = S_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      score_q     <= 32'd0;
      store_cnt_q <= 16'd0;
      cycle_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      store_cnt_q <= store_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign Pass       = (state_q == S_PASS);
  assign Fail       = (state_q == S_FAIL);
  assign Timeout    = (state_q == S_TIMEOUT);
  assign Done       = Pass || Fail || Timeout;
  assign Score      = score_q;
  assign StoreCount = store_cnt_q;
  assign CycleCount = cycle_cnt_q;

endmodule
